// File: rtl/alu_operand_issue_pkg.sv
// Operand-A select encodings, opcodes and buffer types shared by the
// operand-issue block and the ALU rs1 mux.
package alu_operand_issue_pkg;

  typedef enum logic [1:0] {
    SEL_RS1   = 2'd0,
    SEL_IMM_U = 2'd1,
    SEL_IMM_Z = 2'd2
  } rs1_sel_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] imm_u;
    logic [31:0] imm_z;
    logic [4:0]  rs1_addr;
  } issue_entry_t;

endpackage

// File: rtl/alu_operand_decode.sv
// Combinational operand-A decode of one RV32 instruction word.
module alu_operand_decode
  import alu_operand_issue_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [1:0]  sel_o,
  output logic [31:0] imm_u_o,
  output logic [31:0] imm_z_o,
  output logic [4:0]  rs1_addr_o
);

  logic [6:0] opcode;
  assign opcode = inst_i[6:0];

  always_comb begin
    sel_o = SEL_RS1;
    if (opcode == OP_LUI) begin
      sel_o = SEL_IMM_U;
    end else if (opcode == OP_SYSTEM && inst_i[14]) begin
      // funct3[2] set marks the immediate CSR forms
      sel_o = SEL_IMM_Z;
    end
  end

  assign imm_u_o    = {inst_i[31:12], 12'h000};
  assign imm_z_o    = {27'h0, inst_i[19:15]};
  assign rs1_addr_o = inst_i[19:15];

endmodule

// File: rtl/alu_operand_issue.sv
// Decodes incoming instructions and queues operand-A selections in a
// two-entry in-order buffer whose head register drives the outputs.
module alu_operand_issue
  import alu_operand_issue_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  input  logic [31:0] io_in_inst,
  output logic        io_in_ready,
  input  logic        io_flush,
  input  logic        io_out_ready,
  output logic        io_out_valid,
  output logic [1:0]  io_rs1_mux_sel,
  output logic [31:0] io_imm_u,
  output logic [31:0] io_imm_z,
  output logic [4:0]  io_rs1_addr
);

  buf_state_e   state_q, state_d;
  issue_entry_t head_q, head_d;
  issue_entry_t tail_q, tail_d;
  issue_entry_t dec_entry;
  logic         push, pop;

  alu_operand_decode u_decode (
    .inst_i     (io_in_inst),
    .sel_o      (dec_entry.sel),
    .imm_u_o    (dec_entry.imm_u),
    .imm_z_o    (dec_entry.imm_z),
    .rs1_addr_o (dec_entry.rs1_addr)
  );

  assign io_out_valid = (state_q != ST_EMPTY);
  assign io_in_ready  = (state_q != ST_FULL);
  assign push         = io_in_valid && io_in_ready;
  assign pop          = io_out_valid && io_out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (io_flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            head_d  = dec_entry;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_d = dec_entry;
          end else if (push) begin
            state_d = ST_FULL;
            tail_d  = dec_entry;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Payload holds its last value while empty; only the valid flag drops.
  assign io_rs1_mux_sel = head_q.sel;
  assign io_imm_u       = head_q.imm_u;
  assign io_imm_z       = head_q.imm_z;
  assign io_rs1_addr    = head_q.rs1_addr;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed-vector bench for alu_operand_issue with hand-computed expectations.
module tb_alu_operand_issue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_in_valid = 1'b0;
  logic [31:0] io_in_inst = 32'h0;
  logic        io_in_ready;
  logic        io_flush = 1'b0;
  logic        io_out_ready = 1'b0;
  logic        io_out_valid;
  logic [1:0]  io_rs1_mux_sel;
  logic [31:0] io_imm_u;
  logic [31:0] io_imm_z;
  logic [4:0]  io_rs1_addr;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_LUI  = 32'h123450B7; // rs1 field 8
  localparam logic [31:0] I_CSRI = 32'h0002D073; // rs1 field 5
  localparam logic [31:0] I_ADDI = 32'h00308093; // rs1 field 1
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  alu_operand_issue dut (
    .clock          (clock),
    .reset          (reset),
    .io_in_valid    (io_in_valid),
    .io_in_inst     (io_in_inst),
    .io_in_ready    (io_in_ready),
    .io_flush       (io_flush),
    .io_out_ready   (io_out_ready),
    .io_out_valid   (io_out_valid),
    .io_rs1_mux_sel (io_rs1_mux_sel),
    .io_imm_u       (io_imm_u),
    .io_imm_z       (io_imm_z),
    .io_rs1_addr    (io_rs1_addr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {31'h0, io_out_valid}, 32'h0);
    check({tag, "_in_ready"},  {31'h0, io_in_ready},  32'h1);
    check({tag, "_sel"},       {30'h0, io_rs1_mux_sel}, 32'h0);
    check({tag, "_imm_u"},     io_imm_u, 32'h0);
    check({tag, "_imm_z"},     io_imm_z, 32'h0);
    check({tag, "_rs1"},       {27'h0, io_rs1_addr}, 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Decode vectors, streaming through ONE with out_ready high
    io_in_valid = 1'b1; io_in_inst = I_LUI; io_out_ready = 1'b1;
    step();
    check("lui_valid", {31'h0, io_out_valid}, 32'h1);
    check("lui_sel",   {30'h0, io_rs1_mux_sel}, 32'd1);
    check("lui_imm_u", io_imm_u, 32'h12345000);
    check("lui_rs1",   {27'h0, io_rs1_addr}, 32'd8);
    io_in_inst = I_CSRI;
    step();
    check("csri_sel",   {30'h0, io_rs1_mux_sel}, 32'd2);
    check("csri_imm_z", io_imm_z, 32'h5);
    check("csri_rs1",   {27'h0, io_rs1_addr}, 32'd5);
    io_in_inst = I_ADDI;
    step();
    check("addi_sel",   {30'h0, io_rs1_mux_sel}, 32'd0);
    check("addi_rs1",   {27'h0, io_rs1_addr}, 32'd1);
    check("addi_imm_u", io_imm_u, 32'h00308000);
    io_in_inst = I_ILL;
    step();
    check("ill_sel",   {30'h0, io_rs1_mux_sel}, 32'd0);
    check("ill_imm_z", io_imm_z, 32'h1F);
    io_in_valid = 1'b0;
    step();
    check("drain_valid", {31'h0, io_out_valid}, 32'h0);
    check("hold_imm_u",  io_imm_u, 32'hFFFFF000);

    // Back-pressure: fill to FULL, then drain in order
    io_out_ready = 1'b0; io_in_valid = 1'b1; io_in_inst = I_ADDI;
    step();
    check("bp1_ready", {31'h0, io_in_ready}, 32'h1);
    io_in_inst = I_CSRI;
    step();
    check("bp2_ready", {31'h0, io_in_ready}, 32'h0);
    check("bp2_head",  {27'h0, io_rs1_addr}, 32'd1);
    io_in_inst = I_LUI;
    step();
    check("bp3_stable", {27'h0, io_rs1_addr}, 32'd1);
    io_out_ready = 1'b1;
    #1;
    check("full_no_pass", {31'h0, io_in_ready}, 32'h0);
    step();
    check("drain2_rs1", {27'h0, io_rs1_addr}, 32'd5);
    check("drain2_sel", {30'h0, io_rs1_mux_sel}, 32'd2);
    step();
    check("third_rs1", {27'h0, io_rs1_addr}, 32'd8);
    check("third_sel", {30'h0, io_rs1_mux_sel}, 32'd1);
    io_in_valid = 1'b0;
    step();
    check("bp_empty", {31'h0, io_out_valid}, 32'h0);

    // Flush while FULL with simultaneous in/out attempts
    io_out_ready = 1'b0; io_in_valid = 1'b1; io_in_inst = I_ADDI;
    step();
    io_in_inst = I_CSRI;
    step();
    io_flush = 1'b1; io_in_inst = I_LUI; io_out_ready = 1'b1;
    #1;
    check("flush_cyc_ready", {31'h0, io_in_ready}, 32'h0);
    step();
    io_flush = 1'b0; io_in_valid = 1'b0;
    check("flush_valid", {31'h0, io_out_valid}, 32'h0);
    check("flush_ready", {31'h0, io_in_ready},  32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_quiet", {31'h0, io_out_valid}, 32'h0);
    end

    // Asynchronous reset while FULL
    io_out_ready = 1'b0; io_in_valid = 1'b1; io_in_inst = I_ADDI;
    step();
    io_in_inst = I_CSRI;
    step();
    io_in_valid = 1'b0;
    check("pre_rst_full", {31'h0, io_in_ready}, 32'h0);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("arst");
    @(negedge clock);
    reset = 1'b0;
    io_in_valid = 1'b1; io_in_inst = I_LUI; io_out_ready = 1'b1;
    step();
    check("post_rst_valid", {31'h0, io_out_valid}, 32'h1);
    check("post_rst_rs1",   {27'h0, io_rs1_addr}, 32'd8);
    io_in_valid = 1'b0;
    step();
    check("post_rst_empty", {31'h0, io_out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
